fir_ctrl_seq: RTL

Parametrised sequencer for the streaming FIR engine; the next generation of the fixed 11-tap control FSM. It owns the ap_start/ap_done/ap_idle protocol, clears the data buffer at start, and drives circular-buffer BRAM addresses, tap addresses and MAC enables. It also generates AXI-Stream ready/valid/last for a programmable data length and flags TLAST mismatches. It sits between the AXI-Lite register block, the AXI-Stream ports, the tap/data BRAMs and the MAC datapath.

---
 rtl/fir_ctrl_pkg.sv | 32 +++
 rtl/fir_ring_addr.sv | 80 ++++++++
 rtl/fir_ctrl_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg
// Shared definitions for the FIR control sequencer:
//   - state code localparams and the 3-bit state enum built from them
//   - wrap_sub(a, b, n): (a - b) mod n for a, b < n, done as compare-and-add
package fir_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_CALC  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_SEND  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_CLEAR = ST_CLEAR,
    S_LOAD  = ST_LOAD,
    S_CALC  = ST_CALC,
    S_DRAIN = ST_DRAIN,
    S_SEND  = ST_SEND,
    S_DONE  = ST_DONE
  } state_t;

  // Circular-buffer subtraction without a divider: valid only for a, b < n.
  function automatic logic [31:0] wrap_sub(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] n);
    return (a >= b) ? (a - b) : (a + n - b);
  endfunction

endpackage

// File: rtl/fir_ring_addr.sv
// fir_ring_addr
// Holds the circular-buffer head and the per-phase index k, and turns them
// into BRAM addresses according to the sequencer state.
// Ports:
//   axis_clk, axis_rst_n   clock, asynchronous active-low reset
//   state                  current sequencer state
//   head_clr               zero head (run start)
//   head_inc               advance head with wrap (output beat accepted)
//   dat_addr, tap_addr     data / tap BRAM word addresses
//   k_first, k_last        k is at the first / last tap index
module fir_ring_addr
  import fir_ctrl_pkg::*;
#(
  parameter int NUM_TAP = 11,
  parameter int ADDR_W  = 4
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  state_t            state,
  input  logic              head_clr,
  input  logic              head_inc,
  output logic [ADDR_W-1:0] dat_addr,
  output logic [ADDR_W-1:0] tap_addr,
  output logic              k_first,
  output logic              k_last
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TAP - 1);

  logic [ADDR_W-1:0] head_reg, head_next;
  logic [ADDR_W-1:0] k_reg, k_next;
  logic              k_run;

  // k sweeps 0..NUM_TAP-1 in CLEAR and CALC and rests at 0 elsewhere, so
  // each of those phases starts from index 0 without an explicit load.
  assign k_run = (state == S_CLEAR) || (state == S_CALC);

  always_comb begin
    k_next = '0;
    if (k_run && (k_reg != LAST_IDX)) begin
      k_next = k_reg + ADDR_W'(1);
    end
    head_next = head_reg;
    if (head_clr) begin
      head_next = '0;
    end else if (head_inc) begin
      head_next = (head_reg == LAST_IDX) ? '0 : head_reg + ADDR_W'(1);
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      head_reg <= '0;
      k_reg    <= '0;
    end else begin
      head_reg <= head_next;
      k_reg    <= k_next;
    end
  end

  // In CALC the newest sample (at head) pairs with tap 0 and older samples
  // are walked backwards around the ring.
  always_comb begin
    dat_addr = '0;
    tap_addr = '0;
    case (state)
      S_CLEAR: dat_addr = k_reg;
      S_LOAD:  dat_addr = head_reg;
      S_CALC: begin
        dat_addr = ADDR_W'(wrap_sub(32'(head_reg), 32'(k_reg), 32'(NUM_TAP)));
        tap_addr = k_reg;
      end
      default: ;
    endcase
  end

  assign k_first = (k_reg == '0);
  assign k_last  = (k_reg == LAST_IDX);

endmodule

// File: rtl/fir_ctrl_seq.sv
// fir_ctrl_seq
// Control sequencer for the streaming FIR engine: ap_start/ap_done/ap_idle
// handshake, data-buffer clear, circular-buffer and tap addressing, MAC
// enables, AXI-Stream ready/valid/last for a programmable length and a
// sticky TLAST-mismatch flag.
// Ports:
//   axis_clk, axis_rst_n            clock, asynchronous active-low reset
//   ap_start, data_length           run start and sample count (latched)
//   ap_done_ack / ap_done, ap_idle  completion handshake, idle status
//   ss_tvalid, ss_tlast / ss_tready input stream
//   sm_tready / sm_tvalid, sm_tlast output stream
//   dat_we, dat_addr, dat_zero      data BRAM write/address/zero-select
//   tap_addr                        tap BRAM read address
//   mac_clr, mac_en                 MAC load-first-product / accumulate
//   tlast_err                       sticky TLAST mismatch
//   state                           current state code (debug)
module fir_ctrl_seq
  import fir_ctrl_pkg::*;
#(
  parameter int NUM_TAP = 11,
  parameter int ADDR_W  = 4,
  parameter int LEN_W   = 32,
  parameter int MAC_LAT = 2
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic              ap_start,
  input  logic [LEN_W-1:0]  data_length,
  input  logic              ap_done_ack,
  output logic              ap_done,
  output logic              ap_idle,
  input  logic              ss_tvalid,
  input  logic              ss_tlast,
  output logic              ss_tready,
  input  logic              sm_tready,
  output logic              sm_tvalid,
  output logic              sm_tlast,
  output logic              dat_we,
  output logic [ADDR_W-1:0] dat_addr,
  output logic [ADDR_W-1:0] tap_addr,
  output logic              dat_zero,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              tlast_err,
  output logic [2:0]        state
);

  localparam int DRN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

  state_t            state_reg, state_next;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  cnt_reg;
  logic [DRN_W-1:0]  drain_reg;
  logic              tlast_err_reg;

  logic start_acc;
  logic in_beat;
  logic out_beat;
  logic is_last;
  logic k_first;
  logic k_last;

  assign start_acc = (state_reg == S_IDLE) && ap_start;
  assign in_beat   = (state_reg == S_LOAD) && ss_tvalid;
  assign out_beat  = (state_reg == S_SEND) && sm_tready;
  // Only meaningful for a non-zero length; a zero-length run never reaches
  // LOAD or SEND.
  assign is_last   = (cnt_reg == len_reg - LEN_W'(1));

  fir_ring_addr #(
    .NUM_TAP (NUM_TAP),
    .ADDR_W  (ADDR_W)
  ) u_ring (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .state      (state_reg),
    .head_clr   (start_acc),
    .head_inc   (out_beat),
    .dat_addr   (dat_addr),
    .tap_addr   (tap_addr),
    .k_first    (k_first),
    .k_last     (k_last)
  );

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (ap_start) state_next = S_CLEAR;
      S_CLEAR: if (k_last) state_next = (len_reg == '0) ? S_DONE : S_LOAD;
      S_LOAD:  if (ss_tvalid) state_next = S_CALC;
      S_CALC:  if (k_last) state_next = (MAC_LAT == 0) ? S_SEND : S_DRAIN;
      S_DRAIN: if (drain_reg == DRAIN_LAST) state_next = S_SEND;
      S_SEND:  if (sm_tready) state_next = is_last ? S_DONE : S_LOAD;
      S_DONE:  if (ap_done_ack) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      len_reg       <= '0;
      cnt_reg       <= '0;
      drain_reg     <= '0;
      tlast_err_reg <= 1'b0;
    end else begin
      if (start_acc) begin
        len_reg       <= data_length;
        cnt_reg       <= '0;
        tlast_err_reg <= 1'b0;
      end else begin
        if (out_beat) begin
          cnt_reg <= cnt_reg + LEN_W'(1);
        end
        // The stream's own TLAST is only audited; the run length always
        // comes from data_length.
        if (in_beat && (ss_tlast != is_last)) begin
          tlast_err_reg <= 1'b1;
        end
      end
      drain_reg <= (state_reg == S_DRAIN) ? drain_reg + DRN_W'(1) : '0;
    end
  end

  // All outputs decode the registered state; dat_we in LOAD is the one
  // strobe qualified by the input handshake, since the sample is only
  // present on the bus during that beat.
  always_comb begin
    ap_idle   = (state_reg == S_IDLE);
    ap_done   = (state_reg == S_DONE);
    ss_tready = (state_reg == S_LOAD);
    sm_tvalid = (state_reg == S_SEND);
    sm_tlast  = (state_reg == S_SEND) && is_last;
    dat_zero  = (state_reg == S_CLEAR);
    dat_we    = (state_reg == S_CLEAR) || in_beat;
    mac_en    = (state_reg == S_CALC);
    mac_clr   = (state_reg == S_CALC) && k_first;
    tlast_err = tlast_err_reg;
    state     = state_reg;
  end

endmodule
